// File: rtl/snoop_responder_d_pkg.sv
// rtl/snoop_responder_d_pkg.sv - MESI encodings, bus opcodes, address slicing and FSM states
package snoop_responder_d_pkg;
  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAYS     = 4;
  localparam int WAY_W    = 2;
  localparam int NUM_SETS = 1 << INDEX_W;

  localparam int IDX_LSB  = OFFSET_W;
  localparam int IDX_MSB  = OFFSET_W + INDEX_W - 1;
  localparam int TAG_LSB  = OFFSET_W + INDEX_W;
  localparam int TAG_MSB  = ADDR_W - 1;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_BUSRD   = 2'b01,
    OP_BUSRDX  = 2'b10,
    OP_BUSUPGR = 2'b11
  } bus_op_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_RDDATA, ST_FLUSH, ST_UPDATE, ST_DONE
  } snoop_state_t;

  function automatic logic [1:0] snoop_next_state(input bus_op_t op);
    return (op == OP_BUSRD) ? MESI_S : MESI_I;
  endfunction
endpackage

// File: rtl/snoop_responder_d_if.sv
// rtl/snoop_responder_d_if.sv - common-bus snoop, data-array read and local update signals
interface snoop_responder_d_if;
  import snoop_responder_d_pkg::*;

  logic                Snoop_Req;
  logic [1:0]          Bus_Op;
  logic [ADDR_W-1:0]   Address_Com;
  logic [ADDR_W-1:0]   Data_Bus_Com;
  logic                Data_Drive;
  logic                Shared;
  logic                Snoop_Done;
  logic                Snoop_Busy;
  logic [WAY_W-1:0]    Blk_Rd_Way;
  logic [INDEX_W-1:0]  Blk_Rd_Index;
  logic [ADDR_W-1:0]   Blk_Rd_Data;
  logic                Local_Wr;
  logic [INDEX_W-1:0]  Local_Index;
  logic [WAY_W-1:0]    Local_Way;
  logic [TAG_W-1:0]    Local_Tag;
  logic [1:0]          Local_State;

  modport master (
    output Snoop_Req, Bus_Op, Address_Com, Blk_Rd_Data,
           Local_Wr, Local_Index, Local_Way, Local_Tag, Local_State,
    input  Data_Bus_Com, Data_Drive, Shared, Snoop_Done, Snoop_Busy,
           Blk_Rd_Way, Blk_Rd_Index
  );

  modport slave (
    input  Snoop_Req, Bus_Op, Address_Com, Blk_Rd_Data,
           Local_Wr, Local_Index, Local_Way, Local_Tag, Local_State,
    output Data_Bus_Com, Data_Drive, Shared, Snoop_Done, Snoop_Busy,
           Blk_Rd_Way, Blk_Rd_Index
  );
endinterface

// File: rtl/snoop_responder_d_mesi_tag_lookup.sv
// rtl/snoop_responder_d_mesi_tag_lookup.sv - combinational way-parallel tag compare
module mesi_tag_lookup
  import snoop_responder_d_pkg::*;
(
  input  logic [WAYS-1:0][TAG_W-1:0] i_tags,
  input  logic [WAYS-1:0][1:0]       i_states,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_hit,
  output logic [WAY_W-1:0]           o_way,
  output logic [1:0]                 o_state
);
  // Scan downward so that the lowest matching way is the last assignment.
  always_comb begin
    o_hit   = 1'b0;
    o_way   = '0;
    o_state = MESI_I;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (i_states[w] != MESI_I && i_tags[w] == i_tag) begin
        o_hit   = 1'b1;
        o_way   = WAY_W'(w);
        o_state = i_states[w];
      end
    end
  end
endmodule

// File: rtl/snoop_responder_d.sv
// rtl/snoop_responder_d.sv - MESI snoop responder: tag/state arrays, snoop FSM, flush path
// Optional SNOOP_STATS_EN adds saturating hit and flush counters.
module snoop_responder_d
  import snoop_responder_d_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  snoop_responder_d_if.slave  bus
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]         Snoop_Hit_Cnt,
  output logic [15:0]         Snoop_Flush_Cnt
`endif
);
  logic [WAYS-1:0][TAG_W-1:0] r_tags   [NUM_SETS];
  logic [WAYS-1:0][1:0]       r_states [NUM_SETS];

  snoop_state_t         r_state;
  bus_op_t              r_op;
  logic [INDEX_W-1:0]   r_idx;
  logic [TAG_W-1:0]     r_tag;
  logic                 r_hit;
  logic [WAY_W-1:0]     r_hit_way;
  logic                 r_busy, r_done, r_shared, r_drive;
  logic [WAY_W-1:0]     r_rd_way;
  logic [INDEX_W-1:0]   r_rd_idx;

  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic [1:0]           w_hit_state;
  logic                 w_snoop_wr, w_local_drop;
  logic                 w_unused;

  assign w_unused = &{1'b0, bus.Address_Com[OFFSET_W-1:0]};

  mesi_tag_lookup u_lookup (
    .i_tags   (r_tags[r_idx]),
    .i_states (r_states[r_idx]),
    .i_tag    (r_tag),
    .o_hit    (w_hit),
    .o_way    (w_hit_way),
    .o_state  (w_hit_state)
  );

  // A local update racing the snoop's own state write to the same line loses entirely.
  assign w_snoop_wr   = (r_state == ST_UPDATE) && r_hit;
  assign w_local_drop = w_snoop_wr && (bus.Local_Index == r_idx) && (bus.Local_Way == r_hit_way);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_tags[s]   <= '0;
        r_states[s] <= '0;
      end
    end else begin
      if (bus.Local_Wr && !w_local_drop) begin
        r_tags[bus.Local_Index][bus.Local_Way]   <= bus.Local_Tag;
        r_states[bus.Local_Index][bus.Local_Way] <= bus.Local_State;
      end
      if (w_snoop_wr)
        r_states[r_idx][r_hit_way] <= snoop_next_state(r_op);
    end
  end

  // A miss also passes through UPDATE (as a no-op) so every non-flush snoop has the same latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NONE;
      r_idx     <= '0;
      r_tag     <= '0;
      r_hit     <= 1'b0;
      r_hit_way <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_shared  <= 1'b0;
      r_drive   <= 1'b0;
      r_rd_way  <= '0;
      r_rd_idx  <= '0;
    end else begin
      r_done   <= 1'b0;
      r_shared <= 1'b0;
      r_drive  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.Snoop_Req && bus.Bus_Op != OP_NONE) begin
            r_op    <= bus_op_t'(bus.Bus_Op);
            r_idx   <= bus.Address_Com[IDX_MSB:IDX_LSB];
            r_tag   <= bus.Address_Com[TAG_MSB:TAG_LSB];
            r_busy  <= 1'b1;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_hit     <= w_hit;
          r_hit_way <= w_hit_way;
          if (w_hit && w_hit_state == MESI_M && r_op != OP_BUSUPGR) begin
            r_rd_way <= w_hit_way;
            r_rd_idx <= r_idx;
            r_state  <= ST_RDDATA;
          end else begin
            r_state  <= ST_UPDATE;
          end
        end
        ST_RDDATA: begin
          r_drive <= 1'b1;
          r_state <= ST_FLUSH;
        end
        ST_FLUSH:  r_state <= ST_UPDATE;
        ST_UPDATE: begin
          r_done   <= 1'b1;
          r_shared <= r_hit;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Snoop_Busy   = r_busy;
  assign bus.Snoop_Done   = r_done;
  assign bus.Shared       = r_shared;
  assign bus.Data_Drive   = r_drive;
  assign bus.Blk_Rd_Way   = r_rd_way;
  assign bus.Blk_Rd_Index = r_rd_idx;
  assign bus.Data_Bus_Com = r_drive ? bus.Blk_Rd_Data : '0;

`ifdef SNOOP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Snoop_Hit_Cnt   <= '0;
      Snoop_Flush_Cnt <= '0;
    end else begin
      if (r_state == ST_DONE && r_hit && Snoop_Hit_Cnt != 16'hFFFF)
        Snoop_Hit_Cnt <= Snoop_Hit_Cnt + 16'd1;
      if (r_state == ST_FLUSH && Snoop_Flush_Cnt != 16'hFFFF)
        Snoop_Flush_Cnt <= Snoop_Flush_Cnt + 16'd1;
    end
  end
`endif
endmodule
